hex_disp_ctrl: RTL and testbench

HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

---
 rtl/hex_disp_ctrl_if.sv | 24 ++
 rtl/hex_disp_ctrl.sv | 123 ++++++++++++
 tb/tb_hex_disp_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hex_disp_ctrl_if.sv
// Bus between a host and the hex display controller: write port, display
// options, and the registered per-digit outputs.
interface hex_disp_ctrl_if;
  logic        WE;
  logic [31:0] WDATA;
  logic        LZB;
  logic        BLINK;
  logic        PAGE_EN;
  logic [23:0] DIN;
  logic [5:0]  EN;
  logic [5:0]  DOT;
  logic        PAGE;
  logic        UPD;

  modport master (
    output WE, WDATA, LZB, BLINK, PAGE_EN,
    input  DIN, EN, DOT, PAGE, UPD
  );

  modport slave (
    input  WE, WDATA, LZB, BLINK, PAGE_EN,
    output DIN, EN, DOT, PAGE, UPD
  );
endinterface

// File: rtl/hex_disp_ctrl.sv
// Six-digit hex display controller: double-buffered value register updated
// on a display tick, leading-zero blanking, blinking and high-half paging.
module hex_disp_ctrl #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic             CLK,
  input  logic             RST,
  hex_disp_ctrl_if.slave   bus
);
  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic [31:0]   r_shadow;
  logic          r_pending;
  logic [31:0]   r_disp;
  logic          r_upd;
  logic          r_phase;
  logic [1:0]    r_pcnt;
  logic          r_page;
  logic [23:0]   r_din;
  logic [5:0]    r_en;
  logic [5:0]    r_dot;
  logic          r_page_o;

  logic [23:0]   w_din;
  logic [5:0]    w_en;
  logic [5:0]    w_dot;
  logic          w_hi_zero;

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  // Free-running tick divider 0..TICK_DIV-1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  // Shadow/display double buffer; a write coincident with a tick still lets
  // the old shadow reach the display and keeps the new value pending
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_disp    <= '0;
      r_upd     <= 1'b0;
    end else begin
      r_upd <= w_tick & r_pending;
      if (w_tick && r_pending) r_disp <= r_shadow;
      if (bus.WE) begin
        r_shadow  <= bus.WDATA;
        r_pending <= 1'b1;
      end else if (w_tick) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Blink phase and page sequencing, both advanced by the tick
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_phase <= 1'b0;
      r_pcnt  <= '0;
      r_page  <= 1'b0;
    end else begin
      if (w_tick) r_phase <= ~r_phase;
      if (!bus.PAGE_EN) begin
        r_pcnt <= '0;
        r_page <= 1'b0;
      end else if (w_tick) begin
        r_pcnt <= r_pcnt + 2'd1;
        if (r_pcnt == 2'd3) r_page <= ~r_page;
      end
    end
  end

  // Digit selection, leading-zero blanking scanned from the top enabled digit
  always_comb begin
    w_din     = '0;
    w_en      = '0;
    w_dot     = '0;
    w_hi_zero = 1'b1;
    if (r_page) begin
      w_din[7:0] = r_disp[31:24];
      w_en       = 6'b000011;
      w_dot      = 6'b000001;
    end else begin
      w_din = r_disp[23:0];
      w_en  = '1;
    end
    if (bus.LZB) begin
      for (int unsigned k = 5; k >= 1; k--) begin
        if (w_en[k]) begin
          if (w_din[4*k +: 4] == 4'h0 && w_hi_zero) w_en[k] = 1'b0;
          else w_hi_zero = 1'b0;
        end
      end
    end
    if (bus.BLINK && r_phase) w_en = '0;
  end

  // Registered display outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_din    <= '0;
      r_en     <= '0;
      r_dot    <= '0;
      r_page_o <= 1'b0;
    end else begin
      r_din    <= w_din;
      r_en     <= w_en;
      r_dot    <= w_dot;
      r_page_o <= r_page;
    end
  end

  assign bus.DIN  = r_din;
  assign bus.EN   = r_en;
  assign bus.DOT  = r_dot;
  assign bus.PAGE = r_page_o;
  assign bus.UPD  = r_upd;
endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Directed bench for hex_disp_ctrl with TICK_DIV=4. Edge numbers in the
// comments count rising edges after reset release; ticks take effect on
// edges 4, 8, 12, ...
module tb_hex_disp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   upd_seen = 0;
  int   upd_base;

  hex_disp_ctrl_if bus ();

  hex_disp_ctrl #(.TICK_DIV(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.UPD === 1'b1) upd_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [23:0] din, input logic [5:0] en,
                         input logic [5:0] dot, input logic page, input logic upd);
    chk({tag, ".DIN"},  {8'h0, bus.DIN},  {8'h0, din});
    chk({tag, ".EN"},   {26'h0, bus.EN},  {26'h0, en});
    chk({tag, ".DOT"},  {26'h0, bus.DOT}, {26'h0, dot});
    chk({tag, ".PAGE"}, {31'h0, bus.PAGE}, {31'h0, page});
    chk({tag, ".UPD"},  {31'h0, bus.UPD}, {31'h0, upd});
  endtask

  initial begin
    bus.WE = 1'b0; bus.WDATA = '0; bus.LZB = 1'b0; bus.BLINK = 1'b0; bus.PAGE_EN = 1'b0;
    cyc(3);
    chk_all("reset", 24'h0, 6'b000000, 6'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // edge 1: first output after release
    cyc(1);
    chk_all("post_reset", 24'h0, 6'b111111, 6'b0, 1'b0, 1'b0);
    cyc(3);                                           // edge 4: tick, nothing pending
    chk("idle_tick_upd", {31'h0, bus.UPD}, 32'h0);

    // Write right after the tick; loads at edge 8
    bus.WE = 1'b1; bus.WDATA = 32'h12ABCDEF;
    cyc(1);                                           // edge 5
    bus.WE = 1'b0;
    upd_base = upd_seen;
    cyc(3);                                           // edge 8
    chk("wr1_upd", {31'h0, bus.UPD}, 32'h1);
    cyc(1);                                           // edge 9
    chk_all("wr1", 24'hABCDEF, 6'b111111, 6'b0, 1'b0, 1'b0);
    chk("wr1_upd_count", upd_seen - upd_base, 32'd1);

    // Leading-zero blanking of 0x50
    bus.LZB = 1'b1; bus.WE = 1'b1; bus.WDATA = 32'h00000050;
    cyc(1);                                           // edge 10
    bus.WE = 1'b0;
    cyc(2);                                           // edge 12
    chk("lzb_upd", {31'h0, bus.UPD}, 32'h1);
    cyc(1);                                           // edge 13
    chk_all("lzb", 24'h000050, 6'b000011, 6'b0, 1'b0, 1'b0);

    // Pending 0x22222222, then WE coincident with the edge-16 tick
    bus.LZB = 1'b0; bus.WE = 1'b1; bus.WDATA = 32'h22222222;
    upd_base = upd_seen;
    cyc(1);                                           // edge 14
    bus.WE = 1'b0;
    cyc(1);                                           // edge 15
    bus.WE = 1'b1; bus.WDATA = 32'h11111111;
    cyc(1);                                           // edge 16
    bus.WE = 1'b0;
    chk("coin_upd1", {31'h0, bus.UPD}, 32'h1);
    cyc(1);                                           // edge 17
    chk("coin_din1", {8'h0, bus.DIN}, 32'h222222);
    cyc(3);                                           // edge 20
    chk("coin_upd2", {31'h0, bus.UPD}, 32'h1);
    cyc(1);                                           // edge 21
    chk("coin_din2", {8'h0, bus.DIN}, 32'h111111);
    chk("coin_upd_count", upd_seen - upd_base, 32'd2);

    // Paging with display 0xA5000001
    bus.WE = 1'b1; bus.WDATA = 32'hA5000001;
    cyc(1);                                           // edge 22
    bus.WE = 1'b0;
    cyc(3);                                           // edge 25
    chk_all("page0", 24'h000001, 6'b111111, 6'b0, 1'b0, 1'b0);
    bus.PAGE_EN = 1'b1;
    cyc(15);                                          // edge 40: 4th tick flips page
    chk("page_before", {31'h0, bus.PAGE}, 32'h0);
    cyc(1);                                           // edge 41
    chk_all("page1", 24'h0000A5, 6'b000011, 6'b000001, 1'b1, 1'b0);
    bus.PAGE_EN = 1'b0;
    cyc(1);                                           // edge 42
    chk("page_hold", {31'h0, bus.PAGE}, 32'h1);
    cyc(1);                                           // edge 43
    chk_all("page_off", 24'h000001, 6'b111111, 6'b0, 1'b0, 1'b0);

    // Blink: 10 ticks so far, phase 0; edge 44 sets phase 1
    bus.BLINK = 1'b1;
    cyc(1);                                           // edge 44
    chk("blink_44", {26'h0, bus.EN}, {26'h0, 6'b111111});
    cyc(1);                                           // edge 45
    chk("blink_45", {26'h0, bus.EN}, {26'h0, 6'b000000});
    cyc(3);                                           // edge 48
    chk("blink_48", {26'h0, bus.EN}, {26'h0, 6'b000000});
    cyc(1);                                           // edge 49
    chk("blink_49", {26'h0, bus.EN}, {26'h0, 6'b111111});
    cyc(4);                                           // edge 53
    chk("blink_53", {26'h0, bus.EN}, {26'h0, 6'b000000});
    bus.BLINK = 1'b0;

    // Reset during a pending write
    bus.WE = 1'b1; bus.WDATA = 32'hDEADBEEF;
    cyc(1);                                           // edge 54
    bus.WE = 1'b0;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 24'h0, 6'b000000, 6'b0, 1'b0, 1'b0);
    cyc(2);
    rst = 1'b0;
    upd_base = upd_seen;
    cyc(1);                                           // edge 1
    chk_all("rst2_first", 24'h0, 6'b111111, 6'b0, 1'b0, 1'b0);
    bus.LZB = 1'b1;
    cyc(11);                                          // edge 12, ticks at 4, 8, 12
    chk("rst2_upd_count", upd_seen - upd_base, 32'd0);
    chk("rst2_din", {8'h0, bus.DIN}, 32'h0);
    chk("rst2_lzb_en", {26'h0, bus.EN}, {26'h0, 6'b000001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
